// File: rtl/icache_pkg.sv
// icache_pkg: shared types and width helpers for the instruction cache.
//   state_t   - refill FSM state (IDLE, REFILL)
//   offset_w  - word-offset field width for a given words-per-line
//   index_w   - line-index field width for a given line count
//   tag_w     - tag field width for a given word-address width
package icache_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  function automatic int unsigned offset_w(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned index_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned aw,
                                        input int unsigned lines,
                                        input int unsigned words);
    return aw - $clog2(lines) - $clog2(words);
  endfunction

endpackage

// File: rtl/icache_fetch_if.sv
// icache_fetch_if: refill bus between the cache and backing instruction memory.
//   mem_req   - cache -> mem, a refill beat is requested
//   mem_addr  - cache -> mem, word address of the current beat
//   mem_rdata - mem -> cache, beat data
//   mem_ready - mem -> cache, beat accepted and data valid this cycle
// Modports: master (cache side), slave (memory side).
interface icache_fetch_if #(
  parameter int unsigned AW = 30
);
  import icache_pkg::*;

  logic              mem_req;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/icache_line_store.sv
// icache_line_store: valid/tag/data arrays of the direct-mapped cache.
//   rd_index/rd_offset -> rd_valid, rd_tag, rd_data : combinational lookup
//   wr_index           : line addressed by every write-side operation
//   wr_en/wr_offset/wr_data : one data word written per cycle
//   tag_we/wr_tag      : tag write
//   valid_set/valid_clr: set/clear valid[wr_index]; clr_all clears every line
// Only the valid bits are reset; data and tags are don't-care until valid.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4,
  parameter int unsigned TW    = 24,
  parameter int unsigned IW    = index_w(LINES),
  parameter int unsigned OW    = offset_w(WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IW-1:0]     rd_index,
  input  logic [OW-1:0]     rd_offset,
  output logic              rd_valid,
  output logic [TW-1:0]     rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic [IW-1:0]     wr_index,
  input  logic              wr_en,
  input  logic [OW-1:0]     wr_offset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tag_we,
  input  logic [TW-1:0]     wr_tag,
  input  logic              valid_set,
  input  logic              valid_clr,
  input  logic              clr_all
);

  logic [DATA_W-1:0] data_q [LINES][WORDS];
  logic [TW-1:0]     tag_q  [LINES];
  logic [LINES-1:0]  valid_q;

  // Combinational read port
  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_offset];

  // Valid bits: clear-all dominates single-line operations
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (clr_all) begin
      valid_q <= '0;
    end else if (valid_clr) begin
      valid_q[wr_index] <= 1'b0;
    end else if (valid_set) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Data and tag arrays (not reset)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_index][wr_offset] <= wr_data;
    end
    if (tag_we) begin
      tag_q[wr_index] <= wr_tag;
    end
  end

endmodule

// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped read-only instruction cache on the fetch path.
//   clk, reset          - clock, synchronous active-high reset
//   pc_addr, pc_valid   - fetch word address and request
//   flush               - invalidate all lines
//   instr, hit, stall   - combinational lookup result and fetch stall
//   mem (master)        - refill bus: mem_req/mem_addr registered out,
//                         mem_rdata/mem_ready in
// Optional feature macro ICACHE_STATS_EN adds hit_count/miss_count outputs.
module icache_fetch
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4,
  parameter int unsigned AW    = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     pc_addr,
  input  logic              pc_valid,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic              hit,
  output logic              stall,
`ifdef ICACHE_STATS_EN
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
`endif
  icache_fetch_if.master    mem
);

  localparam int unsigned OW = offset_w(WORDS);
  localparam int unsigned IW = index_w(LINES);
  localparam int unsigned TW = tag_w(AW, LINES, WORDS);
  localparam int unsigned LW = AW - OW;

  // Fetch address split
  logic [OW-1:0] pc_off;
  logic [IW-1:0] pc_idx;
  logic [TW-1:0] pc_tag;
  assign pc_off = pc_addr[OW-1:0];
  assign pc_idx = pc_addr[OW +: IW];
  assign pc_tag = pc_addr[AW-1 -: TW];

  // Registered state
  state_t        state_q, state_n;
  logic [OW-1:0] beat_q, beat_n;
  logic [LW-1:0] line_q, line_n;
  logic          req_q, req_n;
  logic [AW-1:0] addr_q, addr_n;
  logic          fpend_q, fpend_n;

  // Line store controls
  logic [IW-1:0]     st_wr_index;
  logic              st_wr_en;
  logic              st_tag_we;
  logic              st_vset;
  logic              st_vclr;
  logic              st_clr_all;
  logic              st_valid;
  logic [TW-1:0]     st_tag;
  logic [DATA_W-1:0] st_data;

  logic [IW-1:0] line_idx;
  logic [TW-1:0] line_tag;
  logic [OW-1:0] beat_inc;
  logic          tag_hit;

  assign line_idx = line_q[IW-1:0];
  assign line_tag = line_q[LW-1 -: TW];
  assign beat_inc = beat_q + OW'(1);

  icache_line_store #(
    .LINES (LINES),
    .WORDS (WORDS),
    .TW    (TW),
    .IW    (IW),
    .OW    (OW)
  ) u_store (
    .clk       (clk),
    .reset     (reset),
    .rd_index  (pc_idx),
    .rd_offset (pc_off),
    .rd_valid  (st_valid),
    .rd_tag    (st_tag),
    .rd_data   (st_data),
    .wr_index  (st_wr_index),
    .wr_en     (st_wr_en),
    .wr_offset (beat_q),
    .wr_data   (mem.mem_rdata),
    .tag_we    (st_tag_we),
    .wr_tag    (line_tag),
    .valid_set (st_vset),
    .valid_clr (st_vclr),
    .clr_all   (st_clr_all)
  );

  // Lookup and stall, combinational from pc_addr
  assign tag_hit = st_valid && (st_tag == pc_tag);
  assign hit     = pc_valid && (state_q == IDLE) && tag_hit;
  assign stall   = (pc_valid && (state_q == IDLE) && !tag_hit) || (state_q == REFILL);
  assign instr   = st_data;

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;

  // Next-state and store-control logic
  always_comb begin
    state_n     = state_q;
    beat_n      = beat_q;
    line_n      = line_q;
    req_n       = req_q;
    addr_n      = addr_q;
    fpend_n     = fpend_q;
    st_wr_index = pc_idx;
    st_wr_en    = 1'b0;
    st_tag_we   = 1'b0;
    st_vset     = 1'b0;
    st_vclr     = 1'b0;
    st_clr_all  = 1'b0;

    case (state_q)
      IDLE: begin
        // A flush wins over starting a refill in the same cycle
        if (flush) begin
          st_clr_all = 1'b1;
        end else if (pc_valid && !tag_hit) begin
          line_n  = {pc_tag, pc_idx};
          beat_n  = '0;
          st_vclr = 1'b1;
          req_n   = 1'b1;
          addr_n  = {pc_tag, pc_idx, OW'(0)};
          fpend_n = 1'b0;
          state_n = REFILL;
        end
      end
      REFILL: begin
        st_wr_index = line_idx;
        if (flush) begin
          fpend_n = 1'b1;
        end
        if (mem.mem_ready) begin
          st_wr_en = 1'b1;
          beat_n   = beat_inc;
          addr_n   = {line_q, beat_inc};
          if (beat_q == OW'(WORDS - 1)) begin
            // A flush seen at any point of the refill leaves the line invalid
            st_tag_we = 1'b1;
            st_vset   = !(fpend_q || flush);
            req_n     = 1'b0;
            fpend_n   = 1'b0;
            state_n   = IDLE;
          end
        end
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      line_q  <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      fpend_q <= 1'b0;
    end else begin
      state_q <= state_n;
      beat_q  <= beat_n;
      line_q  <= line_n;
      req_q   <= req_n;
      addr_q  <= addr_n;
      fpend_q <= fpend_n;
    end
  end

`ifdef ICACHE_STATS_EN
  logic miss_start;
  assign miss_start = (state_q == IDLE) && (state_n == REFILL);

  // Hit/miss counters, free-running with natural wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_start) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// tb_icache_fetch: directed self-checking bench for icache_fetch.
// Memory model returns {16'hC0DE, addr[15:0]} for any beat address.
module tb_icache_fetch;
  import icache_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] pc_addr;
  logic        pc_valid;
  logic        flush;
  logic [31:0] instr;
  logic        hit;
  logic        stall;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  icache_fetch_if #(.AW(30)) mem_if ();

  assign mem_if.mem_rdata = {16'hC0DE, mem_if.mem_addr[15:0]};

  icache_fetch #(
    .LINES (16),
    .WORDS (4),
    .AW    (30)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_addr    (pc_addr),
    .pc_valid   (pc_valid),
    .flush      (flush),
    .instr      (instr),
    .hit        (hit),
    .stall      (stall),
`ifdef ICACHE_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .mem        (mem_if)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Miss on line-aligned address a with mem_ready high; optional flush on one beat
  task automatic do_refill(input logic [29:0] a, input int flush_beat);
    pc_addr = a;
    pc_valid = 1'b1;
    flush = 1'b0;
    mem_if.mem_ready = 1'b1;
    #1;
    chk1("miss_stall", stall, 1'b1);
    chk1("miss_hit", hit, 1'b0);
    cyc();
    for (int b = 0; b < 4; b++) begin
      flush = (b == flush_beat);
      #1;
      chk1("beat_req", mem_if.mem_req, 1'b1);
      chk32("beat_addr", 32'(mem_if.mem_addr), 32'(a) + 32'(b));
      chk1("beat_stall", stall, 1'b1);
      cyc();
    end
    flush = 1'b0;
    #1;
    chk1("post_req", mem_if.mem_req, 1'b0);
    if (flush_beat < 0) begin
      chk1("fill_hit", hit, 1'b1);
      chk1("fill_stall", stall, 1'b0);
      chk32("fill_instr", instr, {16'hC0DE, 16'(a)});
    end else begin
      chk1("flushed_hit", hit, 1'b0);
      chk1("flushed_stall", stall, 1'b1);
    end
  endtask

  logic bp [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int   nbeats;

  initial begin
    reset = 1'b1;
    pc_addr = '0;
    pc_valid = 1'b0;
    flush = 1'b0;
    mem_if.mem_ready = 1'b0;
    cyc();
    cyc();
    cyc();

    // Reset state
    reset = 1'b0;
    #1;
    chk1("rst_req", mem_if.mem_req, 1'b0);
    chk32("rst_addr", 32'(mem_if.mem_addr), 32'h0);
    chk1("rst_hit", hit, 1'b0);
    chk1("rst_stall_idle", stall, 1'b0);
    pc_valid = 1'b1;
    #1;
    chk1("rst_stall_valid", stall, 1'b1);
`ifdef ICACHE_STATS_EN
    chk32("rst_miss_count", miss_count, 32'd0);
`endif

    // Cold miss on 0x10
    do_refill(30'h10, -1);
    cyc();

    // Hits on the rest of the line
    for (int i = 1; i < 4; i++) begin
      pc_addr = 30'h10 + 30'(i);
      #1;
      chk1("line_hit", hit, 1'b1);
      chk1("line_stall", stall, 1'b0);
      chk32("line_instr", instr, 32'hC0DE0010 + 32'(i));
      chk1("line_req", mem_if.mem_req, 1'b0);
      cyc();
    end

    // Conflict eviction: 0x50 shares index 4 with 0x10
    do_refill(30'h50, -1);
    cyc();
    do_refill(30'h10, -1);
`ifdef ICACHE_STATS_EN
    chk32("miss_count", miss_count, 32'd3);
`endif
    cyc();

    // Backpressure on line 0x24
    pc_addr = 30'h24;
    #1;
    chk1("bp_miss", stall, 1'b1);
    cyc();
    nbeats = 0;
    for (int i = 0; i < 7; i++) begin
      mem_if.mem_ready = bp[i];
      #1;
      chk1("bp_req", mem_if.mem_req, 1'b1);
      chk32("bp_addr", 32'(mem_if.mem_addr), 32'h24 + 32'(nbeats));
      if (bp[i]) nbeats++;
      cyc();
    end
    mem_if.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc_addr = 30'h24 + 30'(i);
      #1;
      chk1("bp_hit", hit, 1'b1);
      chk32("bp_instr", instr, 32'hC0DE0024 + 32'(i));
      chk1("bp_req_done", mem_if.mem_req, 1'b0);
      cyc();
    end

    // Flush in IDLE while 0x30 misses: no refill starts
    pc_addr = 30'h30;
    flush = 1'b1;
    #1;
    cyc();
    flush = 1'b0;
    pc_addr = 30'h10;
    #1;
    chk1("flush_no_req", mem_if.mem_req, 1'b0);
    chk1("flush_hit", hit, 1'b0);
    do_refill(30'h10, -1);
    cyc();

    // Flush during beat 2 of a refill: line not validated, misses again
    do_refill(30'h60, 2);
    do_refill(30'h60, -1);
    cyc();

    // Reset mid-refill at beat 2
    pc_addr = 30'h40;
    mem_if.mem_ready = 1'b1;
    #1;
    chk1("rm_miss", stall, 1'b1);
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    chk32("rm_beat2_addr", 32'(mem_if.mem_addr), 32'h42);
    cyc();
    reset = 1'b0;
    #1;
    chk1("rm_req", mem_if.mem_req, 1'b0);
    chk1("rm_hit", hit, 1'b0);
    chk1("rm_stall", stall, 1'b1);
    do_refill(30'h40, -1);
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
# icache_fetch

Direct-mapped, read-only instruction cache between the fetch-stage PC register and a multi-cycle backing instruction memory. Returns the instruction for the current fetch word address in the same cycle on a hit. On a miss it raises a stall into the hazard logic and refills one line, one word per beat, over a simple request/ready bus. It replaces the single-cycle instruction memory on the fetch path.

## Interface
Parameters:
- `LINES`, 16: number of cache lines; power of two, ≥2.
- `WORDS`, 4: 32-bit words per line; power of two, ≥2.
- `AW`, 30: word-address width; the fetch byte address bits [31:2].

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `pc_addr` in AW: fetch word address, PCF[31:2].
- `pc_valid` in 1: a fetch is requested this cycle.
- `flush` in 1: invalidate all lines.
- `instr` out 32: instruction word; meaningful only when `hit`=1.
- `hit` out 1: combinational; `pc_valid` & IDLE & valid[index] & tag match.
- `stall` out 1: combinational; (`pc_valid` & IDLE & !tag-hit) | REFILL. Drives StallF/StallD.
- `mem_req` out 1: refill beat request, registered.
- `mem_addr` out AW: word address of the current beat, registered.
- `mem_rdata` in 32: beat data, sampled when `mem_ready`=1.
- `mem_ready` in 1: beat accepted and data valid this cycle.

## Operation
- Address split: offset = low log2(WORDS) bits; index = next log2(LINES) bits; tag = remaining AW−log2(LINES)−log2(WORDS) bits.
- State per line: valid bit, tag, and WORDS data words. Arrays are flops. The lookup read is combinational.
- The FSM has two states, IDLE and REFILL.
- IDLE:
  - On a hit, present `instr`; no state change.
  - On a miss with `pc_valid`=1 and `flush`=0, latch the line base ({tag,index,0}). Clear the beat counter. Clear valid[index]. Set `mem_req`=1 and `mem_addr`=base. Go to REFILL.
- REFILL:
  - On each cycle with `mem_ready`=1, write `mem_rdata` to word[beat] and increment beat.
  - `mem_addr` always equals base+beat; it is updated registered, so it is correct on the next cycle.
  - On the last beat (beat=WORDS−1 with `mem_ready`), write the tag, set valid, drop `mem_req`, and go to IDLE.
  - `mem_ready` is ignored outside REFILL.
- `flush`:
  - In IDLE, clear all valid bits that cycle. A flush takes priority over starting a refill: no refill starts in a flush cycle.
  - In REFILL, the refill runs to completion, but the line is not validated. A sticky `flush_pend` flag records this and is cleared on return to IDLE.
- `pc_addr` changes during REFILL are tolerated. The refill uses the latched base, and the lookup on return to IDLE uses the current `pc_addr`.
- `reset` is synchronous and active-high:
  - State returns to IDLE; beat=0, `mem_req`=0, `mem_addr`=0.
  - All valid bits clear and `flush_pend`=0.
  - Data and tag arrays are not reset.
  - A reset mid-refill abandons the refill, and the memory side must tolerate the dropped request.
- Reset values of combinational outputs: `hit`=0; `stall`=`pc_valid` (all lines invalid); `instr` is don't-care.

## Timing
- Hit latency: 0 cycles (combinational from `pc_addr`).
- Miss with `mem_ready` tied high, miss detected at cycle 0:
  - Cycles 1..WORDS: refill beats.
  - Cycle WORDS+1: IDLE, hit.
  - `stall` is high for cycles 0..WORDS: WORDS+1 cycles in total.
- Each `mem_ready`=0 cycle extends the refill by one cycle.
- There is no back-to-back refill without an intervening IDLE cycle.

## Configuration
- `ICACHE_STATS_EN`:
  - Defined: adds outputs `hit_count` out 32 and `miss_count` out 32.
    - `hit_count` increments on each IDLE cycle with `hit`=1.
    - `miss_count` increments once per IDLE→REFILL transition.
    - Both wrap at 2^32 and clear on `reset`.
  - Undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Shared package `icache_pkg`: the FSM state enum (IDLE, REFILL), plus functions for the derived widths (offset, index, tag).
- One sub-module, `icache_line_store`:
  - Holds the valid/tag/data arrays with a combinational read port and a one-word write port.
  - Provides tag-write and valid set/clear-all operations.
- The FSM, beat counter, and stats counters live in the top module.

## Test plan
- **Cold miss.** Reset, then `pc_valid`=1, `pc_addr`=0x10, `mem_ready`=1.
  - Expect `mem_addr` 0x10..0x13 on cycles 1–4.
  - Expect `stall` high for 5 cycles, then `hit`=1 with `instr`=mem word 0x10.
- **Hit after fill.** After the cold miss, `pc_addr`=0x11..0x13.
  - Expect `hit`=1 and `stall`=0 each cycle, with correct data and no `mem_req`.
- **Conflict eviction.** Fill 0x10, then fetch 0x50 (same index, different tag), then 0x10 again.
  - Expect two further refills, with `miss_count`=3 when the stats macro is defined.
- **Memory backpressure.** Drive `mem_ready` in the pattern 1,0,0,1,1,0,1.
  - Expect the refill to complete after the 4th ready beat, with the words in order.
- **Flush.**
  - In IDLE: flush after the fill; the next fetch of 0x10 misses.
  - In REFILL: flush during beat 2; the refill finishes, and the next fetch of the same line misses again.
- **Reset mid-refill.** Assert `reset` at beat 2.
  - Expect `mem_req`=0 and `hit`=0 on the next cycle, and a fresh refill starting from the line base afterwards.
